// File: rtl/wb_arbiter_pkg.sv
// +--------------------------------------------------------------+
// | wb_arbiter_pkg: shared widths for the writeback arbiter      |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int HART_ID_W  = 2;
  localparam int REG_ADDR_W = 5;
  localparam int WB_MAX_SRC = 8;

  // Width for an index/count that must hold values 0..v-1, never below 1 bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

`default_nettype wire

// File: rtl/wb_result_fifo.sv
// +--------------------------------------------------------------+
// | wb_result_fifo: per-source result queue, MSB-wrap pointers   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module wb_result_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// +--------------------------------------------------------------+
// | wb_arbiter: EX/WB plus queued sources onto one RF write port |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            exec_valid,
  input  logic                            mem_stall,
  input  logic                            exwb_valid,
  input  logic [HART_ID_W-1:0]            exwb_hart_id,
  input  logic [REG_ADDR_W-1:0]           exwb_rd,
  input  logic [XLEN-1:0]                 exwb_data,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*HART_ID_W-1:0]    src_hart_id,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   src_rd,
  input  logic [NUM_SRC*XLEN-1:0]         src_data,
  output logic                            wb_we,
  output logic [HART_ID_W-1:0]            wb_hart_id,
  output logic [REG_ADDR_W-1:0]           wb_rd,
  output logic [XLEN-1:0]                 wb_data,
  output logic                            wb_stall,
  output logic                            wb_idle
);
  localparam int ENT_W = HART_ID_W + REG_ADDR_W + XLEN;
  localparam int PTR_W = clog2_min1(NUM_SRC);
  localparam int CNT_W = clog2_min1(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [ENT_W-1:0]   heads [NUM_SRC];

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   rr_next;
  logic [CNT_W-1:0]   starve_cnt;
  logic               ex_req;
  logic               ex_force;
  logic               q_any;
  logic               q_grant;
  logic               ex_grant;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      // rd==0 results are accepted but never stored.
      assign src_ready[i] = rst_n && !full[i];
      assign push[i]      = src_valid[i] && src_ready[i] &&
                            (src_rd[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      assign pop[i]       = q_grant && (sel == PTR_W'(i));

      wb_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (QDEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push[i]),
        .push_data ({src_hart_id[i*HART_ID_W +: HART_ID_W],
                     src_rd[i*REG_ADDR_W +: REG_ADDR_W],
                     src_data[i*XLEN +: XLEN]}),
        .pop       (pop[i]),
        .full      (full[i]),
        .empty     (empty[i]),
        .head      (heads[i])
      );
    end
  endgenerate

  assign ex_req   = exec_valid && !mem_stall && exwb_valid && (exwb_rd != '0);
  assign q_any    = !(&empty);
  assign ex_force = ex_req && (starve_cnt >= LIMIT_C);
  assign q_grant  = q_any && !ex_force;
  assign ex_grant = ex_force || (!q_any && ex_req);

  // First non-empty queue at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    sel = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!empty[(int'(rr_ptr) + k) % NUM_SRC]) sel = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
    end
  end

  assign rr_next = (sel == PTR_W'(NUM_SRC - 1)) ? '0 : sel + PTR_W'(1);

  assign wb_we    = q_grant || ex_grant;
  assign wb_stall = ex_req && !ex_grant;
  assign wb_idle  = &empty;
  assign {wb_hart_id, wb_rd, wb_data} = q_grant ? heads[sel]
                                                : {exwb_hart_id, exwb_rd, exwb_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (q_grant) rr_ptr <= rr_next;
      if (wb_stall) begin
        if (starve_cnt < LIMIT_C) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// +--------------------------------------------------------------+
// | tb_wb_arbiter: directed self-checking bench for wb_arbiter   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Instance a: default parameters (STARVE_LIMIT=4)
  logic        a_rst_n, a_exec_valid, a_mem_stall, a_exwb_valid;
  logic [1:0]  a_exwb_hart_id;
  logic [4:0]  a_exwb_rd;
  logic [31:0] a_exwb_data;
  logic [1:0]  a_src_valid, a_src_ready;
  logic [3:0]  a_src_hart_id;
  logic [9:0]  a_src_rd;
  logic [63:0] a_src_data;
  logic        a_wb_we, a_wb_stall, a_wb_idle;
  logic [1:0]  a_wb_hart_id;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;

  // Instance b: STARVE_LIMIT=0, EX always wins
  logic        b_rst_n, b_exec_valid, b_mem_stall, b_exwb_valid;
  logic [1:0]  b_exwb_hart_id;
  logic [4:0]  b_exwb_rd;
  logic [31:0] b_exwb_data;
  logic [1:0]  b_src_valid, b_src_ready;
  logic [3:0]  b_src_hart_id;
  logic [9:0]  b_src_rd;
  logic [63:0] b_src_data;
  logic        b_wb_we, b_wb_stall, b_wb_idle;
  logic [1:0]  b_wb_hart_id;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_data;

  wb_arbiter #(.NUM_SRC(2), .QDEPTH(2), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .exec_valid(a_exec_valid), .mem_stall(a_mem_stall),
    .exwb_valid(a_exwb_valid), .exwb_hart_id(a_exwb_hart_id), .exwb_rd(a_exwb_rd),
    .exwb_data(a_exwb_data), .src_valid(a_src_valid), .src_ready(a_src_ready),
    .src_hart_id(a_src_hart_id), .src_rd(a_src_rd), .src_data(a_src_data),
    .wb_we(a_wb_we), .wb_hart_id(a_wb_hart_id), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
    .wb_stall(a_wb_stall), .wb_idle(a_wb_idle)
  );

  wb_arbiter #(.NUM_SRC(2), .QDEPTH(2), .STARVE_LIMIT(0)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .exec_valid(b_exec_valid), .mem_stall(b_mem_stall),
    .exwb_valid(b_exwb_valid), .exwb_hart_id(b_exwb_hart_id), .exwb_rd(b_exwb_rd),
    .exwb_data(b_exwb_data), .src_valid(b_src_valid), .src_ready(b_src_ready),
    .src_hart_id(b_src_hart_id), .src_rd(b_src_rd), .src_data(b_src_data),
    .wb_we(b_wb_we), .wb_hart_id(b_wb_hart_id), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .wb_stall(b_wb_stall), .wb_idle(b_wb_idle)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; a_src_valid = 2'b11; a_src_rd = {5'd4, 5'd4};
    smp();
    checks++; if (a_src_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", a_src_ready); end
    checks++; if (a_wb_idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b want 1", a_wb_idle); end
    checks++; if (a_wb_we !== 1'b0 || a_wb_stall !== 1'b0) begin fails++; $display("FAIL reset_we_stall: got %b%b want 00", a_wb_we, a_wb_stall); end
    cyc();
    a_rst_n = 1'b1; a_src_valid = 2'b01; a_src_rd = {5'd0, 5'd5};
    a_src_data = {32'd0, 32'h11}; a_src_hart_id = {2'd0, 2'd1};
    smp();
    checks++; if (a_src_ready !== 2'b11) begin fails++; $display("FAIL post_reset_ready: got %b want 11", a_src_ready); end
    checks++; if (a_wb_we !== 1'b0) begin fails++; $display("FAIL no_bypass: got we=%b want 0", a_wb_we); end
    cyc();
    a_src_valid = 2'b00;
    smp();
    checks++; if ({a_wb_we, a_wb_hart_id, a_wb_rd, a_wb_data} !== {1'b1, 2'd1, 5'd5, 32'h11})
      begin fails++; $display("FAIL first_write: got we=%b h=%0d rd=%0d d=%h want we=1 h=1 rd=5 d=11", a_wb_we, a_wb_hart_id, a_wb_rd, a_wb_data); end
    checks++; if (a_wb_idle !== 1'b0) begin fails++; $display("FAIL first_write_idle: got %b want 0", a_wb_idle); end
    cyc();
    smp();
    checks++; if (a_wb_we !== 1'b0 || a_wb_idle !== 1'b1) begin fails++; $display("FAIL after_pop: got we=%b idle=%b want 0 1", a_wb_we, a_wb_idle); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [4];
    logic [4:0]  exp_r [4];
    exp_d = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    exp_r = '{5'd1, 5'd2, 5'd1, 5'd2};
    cyc();
    a_rst_n = 1'b0;
    cyc();
    a_rst_n = 1'b1; a_src_valid = 2'b11; a_src_rd = {5'd2, 5'd1};
    a_src_data = {32'hB0, 32'hA0}; a_src_hart_id = 4'b0;
    cyc();
    a_src_data = {32'hB1, 32'hA1};
    for (int i = 0; i < 4; i++) begin
      if (i == 1) a_src_valid = 2'b00;
      smp();
      checks++; if (a_wb_we !== 1'b1 || a_wb_data !== exp_d[i] || a_wb_rd !== exp_r[i])
        begin fails++; $display("FAIL rr_order[%0d]: got we=%b rd=%0d d=%h want we=1 rd=%0d d=%h", i, a_wb_we, a_wb_rd, a_wb_data, exp_r[i], exp_d[i]); end
      cyc();
    end
    smp();
    checks++; if (a_wb_we !== 1'b0 || a_wb_idle !== 1'b1) begin fails++; $display("FAIL rr_drain: got we=%b idle=%b want 0 1", a_wb_we, a_wb_idle); end
    cyc();
    a_src_valid = 2'b11; a_src_data = {32'hD0, 32'hC0};
    cyc();
    a_src_valid = 2'b00;
    smp();
    checks++; if (a_wb_data !== 32'hC0) begin fails++; $display("FAIL rr_ptr_wrap0: got %h want c0", a_wb_data); end
    cyc();
    smp();
    checks++; if (a_wb_data !== 32'hD0) begin fails++; $display("FAIL rr_ptr_wrap1: got %h want d0", a_wb_data); end
  endtask

  task automatic test_starvation();
    int n;
    cyc();
    a_src_valid = 2'b01; a_src_rd = {5'd0, 5'd7}; a_src_data = {32'd0, 32'h100};
    cyc();
    a_exec_valid = 1'b1; a_exwb_valid = 1'b1; a_exwb_rd = 5'd3;
    a_exwb_data = 32'hE0; a_exwb_hart_id = 2'd2; a_src_data = {32'd0, 32'h101};
    for (int c = 1; c <= 4; c++) begin
      smp();
      checks++; if (a_wb_stall !== 1'b1 || a_wb_rd !== 5'd7 || a_wb_data !== 32'h100 + 32'(c - 1))
        begin fails++; $display("FAIL starve_stall[%0d]: got stall=%b rd=%0d d=%h want 1 7 %h", c, a_wb_stall, a_wb_rd, a_wb_data, 32'h100 + 32'(c - 1)); end
      cyc();
      a_src_data = {32'd0, 32'h101 + 32'(c)};
    end
    smp();
    checks++; if (a_wb_stall !== 1'b0 || a_wb_we !== 1'b1 || a_wb_rd !== 5'd3 || a_wb_data !== 32'hE0 || a_wb_hart_id !== 2'd2)
      begin fails++; $display("FAIL starve_ex_win: got stall=%b we=%b rd=%0d d=%h want 0 1 3 e0", a_wb_stall, a_wb_we, a_wb_rd, a_wb_data); end
    cyc();
    smp();
    checks++; if (a_wb_stall !== 1'b1) begin fails++; $display("FAIL starve_cleared: got stall=%b want 1", a_wb_stall); end
    cyc();
    a_exec_valid = 1'b0; a_exwb_valid = 1'b0; a_src_valid = 2'b00;
    n = 0;
    while (a_wb_idle !== 1'b1 && n < 10) begin cyc(); n++; end
    checks++; if (a_wb_idle !== 1'b1) begin fails++; $display("FAIL starve_drain_timeout: got idle=%b want 1", a_wb_idle); end
  endtask

  task automatic test_ex_gating();
    cyc();
    a_exec_valid = 1'b1; a_exwb_valid = 1'b1; a_exwb_rd = 5'd3; a_mem_stall = 1'b1;
    smp();
    checks++; if (a_wb_we !== 1'b0 || a_wb_stall !== 1'b0) begin fails++; $display("FAIL ex_mem_stall: got we=%b stall=%b want 0 0", a_wb_we, a_wb_stall); end
    cyc();
    a_mem_stall = 1'b0; a_exwb_rd = 5'd0;
    smp();
    checks++; if (a_wb_we !== 1'b0) begin fails++; $display("FAIL ex_rd0: got we=%b want 0", a_wb_we); end
    cyc();
    a_exwb_rd = 5'd9; a_exwb_data = 32'h99;
    smp();
    checks++; if (a_wb_we !== 1'b1 || a_wb_rd !== 5'd9 || a_wb_data !== 32'h99 || a_wb_stall !== 1'b0)
      begin fails++; $display("FAIL ex_only: got we=%b rd=%0d d=%h stall=%b want 1 9 99 0", a_wb_we, a_wb_rd, a_wb_data, a_wb_stall); end
  endtask

  task automatic test_x0_drop();
    cyc();
    a_exec_valid = 1'b0; a_exwb_valid = 1'b0;
    a_src_valid = 2'b01; a_src_rd = 10'd0; a_src_data = {32'd0, 32'hDEAD};
    smp();
    checks++; if (a_src_ready[0] !== 1'b1) begin fails++; $display("FAIL x0_ready: got %b want 1", a_src_ready[0]); end
    cyc();
    a_src_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++; if (a_wb_we !== 1'b0 || a_wb_idle !== 1'b1) begin fails++; $display("FAIL x0_drop[%0d]: got we=%b idle=%b want 0 1", i, a_wb_we, a_wb_idle); end
      cyc();
    end
  endtask

  task automatic test_full_queue();
    cyc();
    b_rst_n = 1'b1; b_exec_valid = 1'b1; b_exwb_valid = 1'b1; b_exwb_rd = 5'd12; b_exwb_data = 32'hEE;
    b_src_valid = 2'b10; b_src_rd = {5'd9, 5'd0}; b_src_data = {32'hA, 32'd0};
    smp();
    checks++; if (b_src_ready[1] !== 1'b1) begin fails++; $display("FAIL full_push0: got ready=%b want 1", b_src_ready[1]); end
    cyc();
    b_src_data = {32'hB, 32'd0};
    smp();
    checks++; if (b_src_ready[1] !== 1'b1 || b_wb_rd !== 5'd12) begin fails++; $display("FAIL full_push1: got ready=%b rd=%0d want 1 12", b_src_ready[1], b_wb_rd); end
    cyc();
    b_src_data = {32'hC, 32'd0};
    smp();
    checks++; if (b_src_ready[1] !== 1'b0 || b_wb_we !== 1'b1 || b_wb_rd !== 5'd12 || b_wb_stall !== 1'b0)
      begin fails++; $display("FAIL full_blocked: got ready=%b we=%b rd=%0d stall=%b want 0 1 12 0", b_src_ready[1], b_wb_we, b_wb_rd, b_wb_stall); end
    cyc();
    b_exec_valid = 1'b0;
    smp();
    checks++; if (b_src_ready[1] !== 1'b0 || b_wb_data !== 32'hA || b_wb_rd !== 5'd9)
      begin fails++; $display("FAIL full_pop_a: got ready=%b d=%h rd=%0d want 0 a 9", b_src_ready[1], b_wb_data, b_wb_rd); end
    cyc();
    smp();
    checks++; if (b_src_ready[1] !== 1'b1 || b_wb_data !== 32'hB) begin fails++; $display("FAIL full_pop_b: got ready=%b d=%h want 1 b", b_src_ready[1], b_wb_data); end
    cyc();
    b_src_valid = 2'b00;
    smp();
    checks++; if (b_wb_we !== 1'b1 || b_wb_data !== 32'hC) begin fails++; $display("FAIL full_pop_c: got we=%b d=%h want 1 c", b_wb_we, b_wb_data); end
    cyc();
    smp();
    checks++; if (b_wb_idle !== 1'b1) begin fails++; $display("FAIL full_drain: got idle=%b want 1", b_wb_idle); end
  endtask

  task automatic test_async_reset();
    cyc();
    b_exec_valid = 1'b1; b_src_valid = 2'b11; b_src_rd = {5'd6, 5'd4}; b_src_data = {32'h61, 32'h41};
    cyc();
    b_src_valid = 2'b01; b_src_data = {32'h0, 32'h42};
    cyc();
    b_src_valid = 2'b00;
    smp();
    checks++; if (b_wb_idle !== 1'b0 || b_wb_rd !== 5'd12) begin fails++; $display("FAIL areset_loaded: got idle=%b rd=%0d want 0 12", b_wb_idle, b_wb_rd); end
    #2;
    b_rst_n = 1'b0;
    #1;
    checks++; if (b_wb_idle !== 1'b1 || b_src_ready !== 2'b00 || b_wb_stall !== 1'b0 || b_wb_we !== 1'b1)
      begin fails++; $display("FAIL areset_immediate: got idle=%b ready=%b stall=%b we=%b want 1 00 0 1", b_wb_idle, b_src_ready, b_wb_stall, b_wb_we); end
    cyc();
    b_exec_valid = 1'b0;
    cyc();
    b_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      checks++; if (b_wb_we !== 1'b0 || b_wb_idle !== 1'b1) begin fails++; $display("FAIL areset_after[%0d]: got we=%b idle=%b want 0 1", i, b_wb_we, b_wb_idle); end
      cyc();
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_exec_valid = 1'b0; a_mem_stall = 1'b0; a_exwb_valid = 1'b0;
    a_exwb_hart_id = 2'd0; a_exwb_rd = 5'd0; a_exwb_data = 32'd0;
    a_src_valid = 2'b00; a_src_hart_id = 4'd0; a_src_rd = 10'd0; a_src_data = 64'd0;
    b_rst_n = 1'b0; b_exec_valid = 1'b0; b_mem_stall = 1'b0; b_exwb_valid = 1'b0;
    b_exwb_hart_id = 2'd0; b_exwb_rd = 5'd0; b_exwb_data = 32'd0;
    b_src_valid = 2'b00; b_src_hart_id = 4'd0; b_src_rd = 10'd0; b_src_data = 64'd0;

    test_reset();
    test_round_robin();
    test_starvation();
    test_ex_gating();
    test_x0_drop();
    test_full_queue();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

`default_nettype wire
